// File: rtl/bitcoin_pkg.sv
// Shared types and defaults for the bitcoin hasher result path.
package bitcoin_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} scanner_state_t;

    localparam int unsigned NUM_NONCES_DEFAULT      = 16;
    localparam int unsigned WORDS_PER_NONCE_DEFAULT = 8;

    typedef logic [7:0] nonce_idx_t;

    // Address of word 0 of a record; wraps modulo 2^16.
    function automatic logic [15:0] record_addr(input logic [15:0] base, input nonce_idx_t idx,
                                                input int unsigned stride);
        logic [31:0] offset;
        offset = 32'(idx) * stride;
        return base + offset[15:0];
    endfunction

endpackage

// File: rtl/hash_min_tracker.sv
// Compare stage: counts H0 values below target and tracks the first match and the minimum H0.
module hash_min_tracker
    import bitcoin_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        valid,
    input  nonce_idx_t  idx,
    input  logic [31:0] h0,
    input  logic [31:0] target,
    output logic        found,
    output nonce_idx_t  first_nonce,
    output logic [8:0]  match_count,
    output nonce_idx_t  best_nonce,
    output logic [31:0] best_hash
);

    logic        found_q;
    nonce_idx_t  first_nonce_q;
    logic [8:0]  match_count_q;
    nonce_idx_t  best_nonce_q;
    logic [31:0] best_hash_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            found_q       <= 1'b0;
            first_nonce_q <= '0;
            match_count_q <= '0;
            best_nonce_q  <= '0;
            best_hash_q   <= 32'hFFFF_FFFF;
        end else if (clear) begin
            found_q       <= 1'b0;
            first_nonce_q <= '0;
            match_count_q <= '0;
            best_nonce_q  <= '0;
            best_hash_q   <= 32'hFFFF_FFFF;
        end else if (valid) begin
            if (h0 < target) begin
                match_count_q <= match_count_q + 9'd1;
                if (!found_q) begin
                    found_q       <= 1'b1;
                    first_nonce_q <= idx;
                end
            end
            // Strict compare: on a tie the earlier index stays.
            if (h0 < best_hash_q) begin
                best_hash_q  <= h0;
                best_nonce_q <= idx;
            end
        end
    end

    assign found       = found_q;
    assign first_nonce = first_nonce_q;
    assign match_count = match_count_q;
    assign best_nonce  = best_nonce_q;
    assign best_hash   = best_hash_q;

endmodule

// File: rtl/nonce_result_scanner.sv
// Walks the per-nonce hash records in memory and reports target matches and the minimum H0.
module nonce_result_scanner
    import bitcoin_pkg::*;
#(
    parameter int unsigned NUM_NONCES      = NUM_NONCES_DEFAULT,
    parameter int unsigned WORDS_PER_NONCE = WORDS_PER_NONCE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] output_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        found,
    output logic [7:0]  first_nonce,
    output logic [8:0]  match_count,
    output logic [7:0]  best_nonce,
    output logic [31:0] best_hash
);

    scanner_state_t state_q, state_d;

    logic [15:0] base_q;
    logic [31:0] target_q;
    nonce_idx_t  idx_q;
    logic        valid_q;
    nonce_idx_t  vidx_q;
    logic [15:0] mem_addr_q;

    logic accept;
    logic last_issue;

    assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_issue = (idx_q == nonce_idx_t'(NUM_NONCES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (last_issue) state_d = DRAIN;
            // Leave only once the final record has passed through the compare stage.
            DRAIN:   if (!valid_q) state_d = DONE;
            DONE:    if (start) state_d = READ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done = (state_q == DONE);
    end

    // Address for record 0 is loaded on the accept edge so issue starts in the first READ cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q     <= '0;
            target_q   <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            vidx_q     <= '0;
            mem_addr_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                base_q     <= output_addr;
                target_q   <= target;
                idx_q      <= '0;
                mem_addr_q <= output_addr;
            end else if (state_q == READ) begin
                valid_q <= 1'b1;
                vidx_q  <= idx_q;
                if (!last_issue) begin
                    idx_q      <= nonce_idx_t'(idx_q + 8'd1);
                    mem_addr_q <= record_addr(base_q, nonce_idx_t'(idx_q + 8'd1), WORDS_PER_NONCE);
                end
            end
        end
    end

    hash_min_tracker u_tracker (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (accept),
        .valid       (valid_q),
        .idx         (vidx_q),
        .h0          (mem_read_data),
        .target      (target_q),
        .found       (found),
        .first_nonce (first_nonce),
        .match_count (match_count),
        .best_nonce  (best_nonce),
        .best_hash   (best_hash)
    );

    assign mem_clk        = clk;
    assign mem_we         = 1'b0;
    assign mem_write_data = '0;
    assign mem_addr       = mem_addr_q;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Directed bench for nonce_result_scanner with a registered-read memory model.
module tb_nonce_result_scanner;

    localparam int N = 16;
    localparam int W = 8;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] output_addr;
    logic [31:0] target;
    logic        done;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        found;
    logic [7:0]  first_nonce;
    logic [8:0]  match_count;
    logic [7:0]  best_nonce;
    logic [31:0] best_hash;

    logic [31:0] mem [0:65535];

    int          n_cmp;
    int          n_bad;
    int          cycles;
    int          low_cnt;
    logic        we_seen;
    logic [15:0] addr_log [0:N-1];

    nonce_result_scanner dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .output_addr    (output_addr),
        .target         (target),
        .done           (done),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .found          (found),
        .first_nonce    (first_nonce),
        .match_count    (match_count),
        .best_nonce     (best_nonce),
        .best_hash      (best_hash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge mem_clk) mem_read_data <= mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // H0 at word 0 of each record, zeros in the other words so a wrong stride is visible.
    task automatic put_record(input logic [15:0] base, input int i, input logic [31:0] h0);
        logic [15:0] a;
        a = base + 16'(i * W);
        mem[a] = h0;
        for (int k = 1; k < W; k++) mem[16'(a + 16'(k))] = 32'h0;
    endtask

    task automatic run_scan(input logic [15:0] base, input logic [31:0] tgt, input bit glitch,
                            input int abort_at);
        @(negedge clk);
        start       = 1'b1;
        output_addr = base;
        target      = tgt;
        @(posedge clk);
        #1;
        start       = 1'b0;
        cycles      = 0;
        low_cnt     = (done == 1'b0) ? 1 : 0;
        we_seen     = mem_we;
        addr_log[0] = mem_addr;
        while (cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            we_seen = we_seen | mem_we;
            if (cycles < N) addr_log[cycles] = mem_addr;
            if (glitch && cycles == 5) begin
                start       = 1'b1;
                output_addr = 16'h0000;
                target      = 32'hFFFF_FFFF;
            end else if (glitch && cycles == 6) begin
                start = 1'b0;
            end
            if (abort_at > 0 && cycles == abort_at) return;
            if (done) break;
            low_cnt++;
        end
        if (!done) check("done_timeout", 32'(done), 32'h1);
    endtask

    task automatic check_addrs(input string tag, input logic [15:0] base);
        for (int i = 0; i < N; i++) check($sformatf("%s_addr%0d", tag, i), 32'(addr_log[i]),
                                          32'(16'(base + 16'(i * W))));
        check({tag, "_we"}, 32'(we_seen), 32'h0);
    endtask

    task automatic check_results(input string tag, input logic f, input logic [7:0] fn,
                                 input logic [8:0] mc, input logic [7:0] bn,
                                 input logic [31:0] bh);
        check({tag, "_found"}, 32'(found), 32'(f));
        check({tag, "_first"}, 32'(first_nonce), 32'(fn));
        check({tag, "_count"}, 32'(match_count), 32'(mc));
        check({tag, "_bnonce"}, 32'(best_nonce), 32'(bn));
        check({tag, "_bhash"}, best_hash, bh);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        output_addr = 16'h0;
        target      = 32'h0;
        for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
        for (int i = 0; i < N; i++) put_record(16'h0100, i, 32'h1000_0000 + 32'(i));
        for (int i = 0; i < N; i++) put_record(16'h0300, i, 32'hF000_0000 - 32'(i));
        for (int i = 0; i < N; i++)
            put_record(16'h0200, i, (i == 3 || i == 9) ? 32'h7 : 32'h8000_0000);
        for (int i = 0; i < N; i++) put_record(16'hFFF8, i, 32'h40 - 32'(2 * i));

        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(done), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_wdata", mem_write_data, 32'h0);
        check_results("rst", 1'b0, 8'd0, 9'd0, 8'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        reset_n = 1'b1;

        // Ascending H0; H0[5] equals the target and must not count.
        run_scan(16'h0100, 32'h1000_0005, 1'b0, 0);
        check("t1_cycles", 32'(cycles), 32'd18);
        check_addrs("t1", 16'h0100);
        check_results("t1", 1'b1, 8'd0, 9'd5, 8'd0, 32'h1000_0000);

        run_scan(16'h0300, 32'h0000_0001, 1'b0, 0);
        check_results("t2", 1'b0, 8'd0, 9'd0, 8'd15, 32'hEFFF_FFF1);

        run_scan(16'h0200, 32'h0000_0008, 1'b0, 0);
        check_results("t3", 1'b1, 8'd3, 9'd2, 8'd3, 32'h0000_0007);

        run_scan(16'hFFF8, 32'h0000_0030, 1'b0, 0);
        check_addrs("t4", 16'hFFF8);
        check_results("t4", 1'b1, 8'd9, 9'd7, 8'd15, 32'h0000_0022);

        // Reset mid-scan after compares for records 0..5 have landed.
        run_scan(16'h0100, 32'h1000_0005, 1'b0, 7);
        check("t5_mid_count", 32'(match_count), 32'd5);
        reset_n = 1'b0;
        #1;
        check("t5_rst_done", 32'(done), 32'h0);
        check("t5_rst_addr", 32'(mem_addr), 32'h0);
        check_results("t5_rst", 1'b0, 8'd0, 9'd0, 8'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        reset_n = 1'b1;
        run_scan(16'h0100, 32'hFFFF_FFFF, 1'b0, 0);
        check("t5_cycles", 32'(cycles), 32'd18);
        check_results("t5", 1'b1, 8'd0, 9'd16, 8'd0, 32'h1000_0000);

        // Restart from DONE with target 0; a start pulse mid-scan must be ignored.
        run_scan(16'h0100, 32'h0000_0000, 1'b1, 0);
        check("t6_cycles", 32'(cycles), 32'd18);
        check("t6_low", 32'(low_cnt), 32'd18);
        check_addrs("t6", 16'h0100);
        check_results("t6", 1'b0, 8'd0, 9'd0, 8'd0, 32'h1000_0000);

        repeat (5) @(posedge clk);
        #1;
        check("t6_hold_done", 32'(done), 32'h1);
        check("t6_hold_hash", best_hash, 32'h1000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
